// File: rtl/out_seq_ctrl_pkg.sv
// Shared definitions for the output sequencing controller, the compute core
// and the result register: state codes and result-word geometry.
package out_seq_ctrl_pkg;

    // State codes on st. CAPT = 3'b101 is decoded by the result register
    // as its capture strobe, so these values must not be renumbered.
    localparam logic [2:0] ST_IDLE = 3'b000;
    localparam logic [2:0] ST_LOAD = 3'b001;
    localparam logic [2:0] ST_CALC = 3'b010;
    localparam logic [2:0] ST_CAPT = 3'b101;
    localparam logic [2:0] ST_SEND = 3'b110;
    localparam logic [2:0] ST_FIN  = 3'b111;

    // Result register geometry: NWORDS words of WW bits each.
    localparam int NWORDS = 8;
    localparam int WW     = 32;

    // Maps the sequential word count onto the DOk index. For a 3-bit count,
    // 7 - cnt is the bitwise complement, so MSW-first order needs no subtractor.
    function automatic logic [2:0] word_index(input logic [2:0] cnt, input logic msw_first);
        return msw_first ? ~cnt : cnt;
    endfunction

endpackage

// File: rtl/out_seq_ctrl.sv
// Sequencing controller for the 256-bit result register: drives the shared
// state code and round counter, then streams the eight result words over a
// 32-bit valid/ready interface and pulses DONE after the last transfer.
module out_seq_ctrl
    import out_seq_ctrl_pkg::*;
#(
    parameter int unsigned ROUNDS    = 64,
    parameter int unsigned RW        = 6,
    parameter bit          MSW_FIRST = 1'b0
) (
    input  logic          CLK,
    input  logic          rst,
    input  logic          start,
    input  logic [WW-1:0] DO0,
    input  logic [WW-1:0] DO1,
    input  logic [WW-1:0] DO2,
    input  logic [WW-1:0] DO3,
    input  logic [WW-1:0] DO4,
    input  logic [WW-1:0] DO5,
    input  logic [WW-1:0] DO6,
    input  logic [WW-1:0] DO7,
    output logic [2:0]    st,
    output logic [RW-1:0] RND,
    output logic [WW-1:0] ODATA,
    output logic          OVALID,
    input  logic          OREADY,
    output logic [2:0]    OIDX,
    output logic          BUSY,
    output logic          DONE
);

    // Terminal round value; ROUNDS = 2^RW still fits because the compare
    // is against ROUNDS-1.
    localparam logic [RW-1:0] RND_LAST = RW'(ROUNDS - 1);

    logic [2:0]    st_q;
    logic [2:0]    st_d;
    logic [RW-1:0] rnd_q;
    logic [2:0]    cnt_q;
    logic          in_send;
    logic          xfer;
    logic          last_round;
    logic          last_word;

    assign in_send    = (st_q == ST_SEND);
    assign xfer       = in_send & OREADY;
    assign last_round = (rnd_q == RND_LAST);
    assign last_word  = (cnt_q == 3'(NWORDS - 1));

    // Next-state decode; unused codes fall back to IDLE.
    always_comb begin
        // NOTE: default first so every path assigns st_d and no latch is inferred.
        st_d = st_q;
        case (st_q)
            ST_IDLE: if (start) st_d = ST_LOAD;
            ST_LOAD: st_d = ST_CALC;
            ST_CALC: if (last_round) st_d = ST_CAPT;
            ST_CAPT: st_d = ST_SEND;
            ST_SEND: if (xfer && last_word) st_d = ST_FIN;
            ST_FIN:  st_d = ST_IDLE;
            default: st_d = ST_IDLE;
        endcase
    end

    // State register with synchronous reset taking priority over everything.
    always_ff @(posedge CLK) begin
        // NOTE: sequential state uses non-blocking assignments so all registers
        // update together from pre-edge values.
        if (rst) begin
            st_q <= ST_IDLE;
        end else begin
            st_q <= st_d;
        end
    end

    // Round counter: counts only in CALC and sits at zero everywhere else,
    // including the cycle after the terminal round.
    always_ff @(posedge CLK) begin
        if (rst) begin
            rnd_q <= '0;
        end else if (st_q == ST_CALC && !last_round) begin
            rnd_q <= rnd_q + RW'(1);
        end else begin
            rnd_q <= '0;
        end
    end

    // Word counter: cleared in CAPT, advances on each accepted word; its
    // natural 7 -> 0 wrap coincides with the exit to FIN.
    always_ff @(posedge CLK) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (st_q == ST_CAPT) begin
            cnt_q <= '0;
        end else if (xfer) begin
            cnt_q <= cnt_q + 3'd1;
        end
    end

    assign st     = st_q;
    assign RND    = rnd_q;
    assign OVALID = in_send;
    assign BUSY   = (st_q != ST_IDLE);
    assign DONE   = (st_q == ST_FIN);
    assign OIDX   = in_send ? word_index(cnt_q, MSW_FIRST) : 3'd0;

    // 8:1 word mux onto ODATA, forced to zero outside SEND.
    always_comb begin
        ODATA = '0;
        if (in_send) begin
            case (OIDX)
                3'd0:    ODATA = DO0;
                3'd1:    ODATA = DO1;
                3'd2:    ODATA = DO2;
                3'd3:    ODATA = DO3;
                3'd4:    ODATA = DO4;
                3'd5:    ODATA = DO5;
                3'd6:    ODATA = DO6;
                default: ODATA = DO7;
            endcase
        end
    end

endmodule

// File: tb/tb_out_seq_ctrl.sv
// Self-checking bench for out_seq_ctrl: four instances cover ROUNDS = 4
// (LSW and MSW first), ROUNDS = 1 and ROUNDS = 64. Expected words are
// queued when an operation is started and popped as transfers occur.
module tb_out_seq_ctrl;
    import out_seq_ctrl_pkg::*;

    typedef struct {
        logic [2:0]  idx;
        logic [31:0] data;
    } exp_t;

    logic        CLK = 1'b0;
    logic        rst;
    logic        OREADY;
    logic [31:0] do_w     [8];
    logic        start_v  [4];
    logic [2:0]  st_v     [4];
    logic [5:0]  rnd_v    [4];
    logic [31:0] odata_v  [4];
    logic        ovalid_v [4];
    logic [2:0]  oidx_v   [4];
    logic        busy_v   [4];
    logic        done_v   [4];

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    always #5 CLK = ~CLK;

    out_seq_ctrl #(.ROUNDS(4), .RW(6), .MSW_FIRST(1'b0)) dut_a (
        .CLK(CLK), .rst(rst), .start(start_v[0]),
        .DO0(do_w[0]), .DO1(do_w[1]), .DO2(do_w[2]), .DO3(do_w[3]),
        .DO4(do_w[4]), .DO5(do_w[5]), .DO6(do_w[6]), .DO7(do_w[7]),
        .st(st_v[0]), .RND(rnd_v[0]), .ODATA(odata_v[0]), .OVALID(ovalid_v[0]),
        .OREADY(OREADY), .OIDX(oidx_v[0]), .BUSY(busy_v[0]), .DONE(done_v[0]));

    out_seq_ctrl #(.ROUNDS(4), .RW(6), .MSW_FIRST(1'b1)) dut_b (
        .CLK(CLK), .rst(rst), .start(start_v[1]),
        .DO0(do_w[0]), .DO1(do_w[1]), .DO2(do_w[2]), .DO3(do_w[3]),
        .DO4(do_w[4]), .DO5(do_w[5]), .DO6(do_w[6]), .DO7(do_w[7]),
        .st(st_v[1]), .RND(rnd_v[1]), .ODATA(odata_v[1]), .OVALID(ovalid_v[1]),
        .OREADY(OREADY), .OIDX(oidx_v[1]), .BUSY(busy_v[1]), .DONE(done_v[1]));

    out_seq_ctrl #(.ROUNDS(1), .RW(6), .MSW_FIRST(1'b0)) dut_c (
        .CLK(CLK), .rst(rst), .start(start_v[2]),
        .DO0(do_w[0]), .DO1(do_w[1]), .DO2(do_w[2]), .DO3(do_w[3]),
        .DO4(do_w[4]), .DO5(do_w[5]), .DO6(do_w[6]), .DO7(do_w[7]),
        .st(st_v[2]), .RND(rnd_v[2]), .ODATA(odata_v[2]), .OVALID(ovalid_v[2]),
        .OREADY(OREADY), .OIDX(oidx_v[2]), .BUSY(busy_v[2]), .DONE(done_v[2]));

    out_seq_ctrl #(.ROUNDS(64), .RW(6), .MSW_FIRST(1'b0)) dut_d (
        .CLK(CLK), .rst(rst), .start(start_v[3]),
        .DO0(do_w[0]), .DO1(do_w[1]), .DO2(do_w[2]), .DO3(do_w[3]),
        .DO4(do_w[4]), .DO5(do_w[5]), .DO6(do_w[6]), .DO7(do_w[7]),
        .st(st_v[3]), .RND(rnd_v[3]), .ODATA(odata_v[3]), .OVALID(ovalid_v[3]),
        .OREADY(OREADY), .OIDX(oidx_v[3]), .BUSY(busy_v[3]), .DONE(done_v[3]));

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    // One full operation on instance s with ROUNDS r. While the front of the
    // queue has index stall_idx, OREADY is held low for stall_len cycles.
    task automatic run_op(input int s, input int r, input bit msw, input int stall_idx,
                          input int stall_len, input bit start_calc, input bit start_fin);
        int   n;
        int   sends;
        int   stall_left;
        exp_t e;
        stall_left = stall_len;
        check("idle_st", 64'(st_v[s]), 64'(ST_IDLE));
        for (int k = 0; k < 8; k++) begin
            e.idx  = msw ? 3'(7 - k) : 3'(k);
            e.data = 32'h11111111 * {29'd0, e.idx};
            sb.push_back(e);
        end
        start_v[s] = 1'b1;
        OREADY     = 1'b1;
        @(negedge CLK);
        n = 1;
        start_v[s] = 1'b0;
        check("load_st", 64'(st_v[s]), 64'(ST_LOAD));
        check("load_rnd", 64'(rnd_v[s]), 64'd0);
        check("load_busy", 64'(busy_v[s]), 64'd1);
        check("load_ovalid", 64'(ovalid_v[s]), 64'd0);
        for (int i = 0; i < r; i++) begin
            @(negedge CLK);
            n++;
            check("calc_st", 64'(st_v[s]), 64'(ST_CALC));
            check("calc_rnd", 64'(rnd_v[s]), 64'(i));
            check("calc_done", 64'(done_v[s]), 64'd0);
            start_v[s] = start_calc && (i == 0);
        end
        @(negedge CLK);
        n++;
        start_v[s] = 1'b0;
        check("capt_st", 64'(st_v[s]), 64'(ST_CAPT));
        check("capt_rnd", 64'(rnd_v[s]), 64'd0);
        check("capt_ovalid", 64'(ovalid_v[s]), 64'd0);
        sends = 0;
        while (sb.size() > 0 && sends < 64) begin
            @(negedge CLK);
            n++;
            sends++;
            check("send_st", 64'(st_v[s]), 64'(ST_SEND));
            check("send_ovalid", 64'(ovalid_v[s]), 64'd1);
            check("send_oidx", 64'(oidx_v[s]), 64'(sb[0].idx));
            check("send_odata", 64'(odata_v[s]), 64'(sb[0].data));
            check("send_done", 64'(done_v[s]), 64'd0);
            if (sb[0].idx == 3'(stall_idx) && stall_left > 0) begin
                OREADY = 1'b0;
                stall_left--;
            end else begin
                OREADY = 1'b1;
                void'(sb.pop_front());
            end
        end
        if (sb.size() > 0) begin
            check("send_timeout", 64'(sb.size()), 64'd0);
            sb.delete();
        end
        OREADY = 1'b1;
        @(negedge CLK);
        n++;
        check("fin_st", 64'(st_v[s]), 64'(ST_FIN));
        check("fin_done", 64'(done_v[s]), 64'd1);
        check("fin_ovalid", 64'(ovalid_v[s]), 64'd0);
        check("fin_odata", 64'(odata_v[s]), 64'd0);
        check("fin_oidx", 64'(oidx_v[s]), 64'd0);
        check("latency", 64'(n), 64'(r + 11 + stall_len));
        check("send_cycles", 64'(sends), 64'(8 + stall_len));
        start_v[s] = start_fin;
        @(negedge CLK);
        start_v[s] = 1'b0;
        check("post_st", 64'(st_v[s]), 64'(ST_IDLE));
        check("post_done", 64'(done_v[s]), 64'd0);
        check("post_busy", 64'(busy_v[s]), 64'd0);
    endtask

    // Starts an operation on dut_a and asserts rst either at OIDX = 4 in SEND
    // (mode 0) or at RND = 2 in CALC (mode 1).
    task automatic reset_mid(input int mode);
        bit found;
        found = 1'b0;
        start_v[0] = 1'b1;
        OREADY     = 1'b1;
        @(negedge CLK);
        start_v[0] = 1'b0;
        for (int c = 0; c < 100 && !found; c++) begin
            if (mode == 0) found = (st_v[0] == ST_SEND) && (oidx_v[0] == 3'd4);
            else           found = (st_v[0] == ST_CALC) && (rnd_v[0] == 6'd2);
            if (!found) @(negedge CLK);
        end
        check("abort_found", 64'(found), 64'd1);
        rst = 1'b1;
        @(negedge CLK);
        rst = 1'b0;
        check("abort_st", 64'(st_v[0]), 64'(ST_IDLE));
        check("abort_ovalid", 64'(ovalid_v[0]), 64'd0);
        check("abort_rnd", 64'(rnd_v[0]), 64'd0);
        check("abort_busy", 64'(busy_v[0]), 64'd0);
        check("abort_odata", 64'(odata_v[0]), 64'd0);
        check("abort_oidx", 64'(oidx_v[0]), 64'd0);
        for (int c = 0; c < 3; c++) begin
            check("abort_done", 64'(done_v[0]), 64'd0);
            @(negedge CLK);
            check("abort_idle", 64'(st_v[0]), 64'(ST_IDLE));
        end
    endtask

    initial begin
        for (int k = 0; k < 8; k++) do_w[k] = 32'h11111111 * 32'(k);
        for (int i = 0; i < 4; i++) start_v[i] = 1'b0;
        rst    = 1'b1;
        OREADY = 1'b1;
        repeat (2) @(negedge CLK);

        // Reset state of every instance.
        for (int i = 0; i < 4; i++) begin
            check("rst_st", 64'(st_v[i]), 64'(ST_IDLE));
            check("rst_rnd", 64'(rnd_v[i]), 64'd0);
            check("rst_ovalid", 64'(ovalid_v[i]), 64'd0);
            check("rst_done", 64'(done_v[i]), 64'd0);
            check("rst_busy", 64'(busy_v[i]), 64'd0);
            check("rst_odata", 64'(odata_v[i]), 64'd0);
            check("rst_oidx", 64'(oidx_v[i]), 64'd0);
        end
        rst = 1'b0;
        @(negedge CLK);

        // Basic run, then 3-cycle backpressure at OIDX = 2.
        run_op(0, 4, 1'b0, -1, 0, 1'b0, 1'b0);
        run_op(0, 4, 1'b0, 2, 3, 1'b0, 1'b0);

        // MSW-first ordering.
        run_op(1, 4, 1'b1, -1, 0, 1'b0, 1'b0);

        // start during CALC and FIN is ignored; start in the following IDLE
        // cycle begins the next operation immediately.
        run_op(0, 4, 1'b0, -1, 0, 1'b1, 1'b1);
        run_op(0, 4, 1'b0, -1, 0, 1'b0, 1'b0);

        // Reset in SEND at OIDX = 4, then a clean run restarting at word 0.
        reset_mid(0);
        run_op(0, 4, 1'b0, -1, 0, 1'b0, 1'b0);

        // Reset in CALC at RND = 2.
        reset_mid(1);
        run_op(0, 4, 1'b0, 5, 1, 1'b0, 1'b0);

        // Round-count boundaries.
        run_op(2, 1, 1'b0, -1, 0, 1'b0, 1'b0);
        run_op(3, 64, 1'b0, 7, 2, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
